// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock/run controller: FSM state encodings,
// request priority order and the legal range of the reset hold count.
package clk_ctrl_pkg;

    // FSM state encodings, also driven out on the state port.
    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_REL   = 3'd1,
        ST_HALT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_BURST = 3'd5
    } state_t;

    // Front-panel request kinds, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_HALT  = 3'd1,
        REQ_STEP  = 3'd2,
        REQ_BURST = 3'd3,
        REQ_RUN   = 3'd4
    } req_t;

    // Legal range for the number of cycles _mrPos is held low.
    localparam int HOLD_CYCLES_MIN = 1;
    localparam int HOLD_CYCLES_MAX = 255;

    // Picks the single winning request when several edges land together:
    // halt beats step, step beats burst, burst beats run.
    function automatic req_t pick_req(input logic halt, input logic step,
                                      input logic burst, input logic run);
        req_t winner;
        winner = REQ_NONE;
        if (halt)       winner = REQ_HALT;
        else if (step)  winner = REQ_STEP;
        else if (burst) winner = REQ_BURST;
        else if (run)   winner = REQ_RUN;
        return winner;
    endfunction

endpackage

// File: rtl/req_edge.sv
// Request edge detector: captures a front-panel level into a flop, keeps the
// previous captured value, and pulses for one cycle on a 0->1 transition.
module req_edge (
    input  logic system_clk,
    input  logic reset,
    input  logic req,
    output logic pulse
);

    logic sync_q;
    logic prev_q;

    // Capture stage plus history flop; both cleared by reset so a level held
    // across reset shows up as a fresh edge once reset is gone.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= req;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/clock_run_controller.sv
// Clock/run controller: staged master-reset release followed by the
// run/halt/step/burst clock-enable FSM feeding the external clock gate.
// Optional feature macro: CLK_CTRL_CYCLE_COUNT_EN adds the cycle_count output.
module clock_run_controller
    import clk_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int BURST_W     = 8,
    parameter int START_RUN   = 0
) (
    input  logic               system_clk,
    input  logic               reset,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               burst_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               cpu_halt,
    output logic               _mrPos,
    output logic               _mrNeg,
    output logic               clk_en,
    output logic [2:0]         state
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]        cycle_count
`endif
);

    // Out-of-range hold counts are clamped into the supported window.
    localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_CYCLES_MIN) ? HOLD_CYCLES_MIN :
                              (HOLD_CYCLES > HOLD_CYCLES_MAX) ? HOLD_CYCLES_MAX :
                              HOLD_CYCLES;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_EFF - 1);

    logic run_pulse, halt_pulse, step_pulse, burst_pulse;
    logic cpu_halt_q, cpu_halt_prev_q, cpu_halt_rise;

    state_t             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               mr_pos_q, mr_pos_d;
    logic               mr_neg_q, mr_neg_d;
    logic               clk_en_q, clk_en_d;
    req_t               winner;

    req_edge u_run_edge   (.system_clk(system_clk), .reset(reset), .req(run_req),   .pulse(run_pulse));
    req_edge u_halt_edge  (.system_clk(system_clk), .reset(reset), .req(halt_req),  .pulse(halt_pulse));
    req_edge u_step_edge  (.system_clk(system_clk), .reset(reset), .req(step_req),  .pulse(step_pulse));
    req_edge u_burst_edge (.system_clk(system_clk), .reset(reset), .req(burst_req), .pulse(burst_pulse));

    // CPU halt flag goes through the same capture stage as the requests; the
    // level stops RUN, the rising edge aborts a burst.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            cpu_halt_q      <= 1'b0;
            cpu_halt_prev_q <= 1'b0;
        end else begin
            cpu_halt_q      <= cpu_halt;
            cpu_halt_prev_q <= cpu_halt_q;
        end
    end

    assign cpu_halt_rise = cpu_halt_q & ~cpu_halt_prev_q;

    // State register with the counters, master resets and clk_en flop.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RST;
            hold_q   <= '0;
            burst_q  <= '0;
            mr_pos_q <= 1'b0;
            mr_neg_q <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            burst_q  <= burst_d;
            mr_pos_q <= mr_pos_d;
            mr_neg_q <= mr_neg_d;
            clk_en_q <= clk_en_d;
        end
    end

    // Next-state logic; clk_en is registered from the next state so the
    // enable is high for exactly the cycles spent in RUN, STEP or BURST.
    always_comb begin
        state_d  = ST_HALT;
        hold_d   = hold_q;
        burst_d  = burst_q;
        mr_pos_d = mr_pos_q;
        mr_neg_d = mr_neg_q;
        winner   = pick_req(halt_pulse, step_pulse, burst_pulse, run_pulse);

        case (state_q)
            ST_RST: begin
                state_d = ST_RST;
                if (hold_q == HOLD_LAST) begin
                    state_d  = ST_REL;
                    mr_pos_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_REL: begin
                mr_neg_d = 1'b1;
                state_d  = (START_RUN != 0) ? ST_RUN : ST_HALT;
            end
            ST_HALT: begin
                state_d = ST_HALT;
                case (winner)
                    REQ_STEP:  state_d = ST_STEP;
                    REQ_BURST: begin
                        if (burst_len != '0) begin
                            state_d = ST_BURST;
                            burst_d = burst_len;
                        end
                    end
                    REQ_RUN: begin
                        if (!cpu_halt_q) state_d = ST_RUN;
                    end
                    default:   state_d = ST_HALT;
                endcase
            end
            ST_RUN: begin
                state_d = (halt_pulse || cpu_halt_q) ? ST_HALT : ST_RUN;
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_BURST: begin
                if (halt_pulse || cpu_halt_rise || burst_q == BURST_W'(1)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_BURST;
                    burst_d = burst_q - BURST_W'(1);
                end
            end
            default: state_d = ST_HALT;
        endcase

        clk_en_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_BURST);
    end

`ifdef CLK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_q;

    // Counts enabled CPU clocks; held at zero while the machine is in reset.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (state_q == ST_RST) begin
            cycle_q <= '0;
        end else if (clk_en_q) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
`endif

    assign _mrPos = mr_pos_q;
    assign _mrNeg = mr_neg_q;
    assign clk_en = clk_en_q;
    assign state  = state_q;

endmodule

// File: tb/tb_clock_run_controller.sv
// Directed bench for clock_run_controller (HOLD_CYCLES=4, START_RUN=0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_run_controller;

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_REL   = 3'd1;
    localparam logic [2:0] S_HALT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_BURST = 3'd5;

    logic       system_clk = 1'b0;
    logic       reset      = 1'b1;
    logic       run_req    = 1'b0;
    logic       halt_req   = 1'b0;
    logic       step_req   = 1'b0;
    logic       burst_req  = 1'b0;
    logic [7:0] burst_len  = 8'd0;
    logic       cpu_halt   = 1'b0;
    logic       mr_pos, mr_neg, clk_en;
    logic [2:0] state;
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    int tests_run  = 0;
    int tests_fail = 0;
    int highs, first, last;

    clock_run_controller #(.HOLD_CYCLES(4), .BURST_W(8), .START_RUN(0)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .burst_req  (burst_req),
        .burst_len  (burst_len),
        .cpu_halt   (cpu_halt),
        ._mrPos     (mr_pos),
        ._mrNeg     (mr_neg),
        .clk_en     (clk_en),
        .state      (state)
`ifdef CLK_CTRL_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    // Free-running 10 ns clock.
    always #5 system_clk = ~system_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic s, input logic b,
                                 input logic r, input logic ch, input logic [7:0] len);
        halt_req  = h;
        step_req  = s;
        burst_req = b;
        run_req   = r;
        cpu_halt  = ch;
        burst_len = len;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge system_clk);
    endtask

    // Counts cycles with clk_en high over a window; first/last are 1-based.
    task automatic countEnables(input int cycles, output int n_high,
                                output int first_i, output int last_i);
        n_high  = 0;
        first_i = -1;
        last_i  = -1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge system_clk);
            if (clk_en) begin
                n_high++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
    endtask

    // Expects reset to have just been dropped on a falling edge.
    task automatic releaseSequence(input string tag);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checkOutput({tag, "_mrpos_held"}, {31'd0, mr_pos}, 32'd0);
        end
        tick(1);
        checkOutput({tag, "_mrpos_rise"}, {31'd0, mr_pos}, 32'd1);
        checkOutput({tag, "_mrneg_still_low"}, {31'd0, mr_neg}, 32'd0);
        checkOutput({tag, "_state_rel"}, {29'd0, state}, {29'd0, S_REL});
        tick(1);
        checkOutput({tag, "_mrneg_rise"}, {31'd0, mr_neg}, 32'd1);
        checkOutput({tag, "_state_halt"}, {29'd0, state}, {29'd0, S_HALT});
        checkOutput({tag, "_clk_en_off"}, {31'd0, clk_en}, 32'd0);
    endtask

    initial begin
        // Reset state and release sequence.
        tick(2);
        checkOutput("rst_state", {29'd0, state}, {29'd0, S_RST});
        checkOutput("rst_mrpos", {31'd0, mr_pos}, 32'd0);
        checkOutput("rst_mrneg", {31'd0, mr_neg}, 32'd0);
        checkOutput("rst_clk_en", {31'd0, clk_en}, 32'd0);
        reset = 1'b0;
        releaseSequence("rel1");

        // Held step request gives exactly one enabled cycle.
        applyStimulus(0, 1, 0, 0, 0, 8'd0);
        countEnables(10, highs, first, last);
        checkOutput("step_highs", highs, 32'd1);
        checkOutput("step_latency", first, 32'd2);
        checkOutput("step_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);

        // Burst of five consecutive enables, then a zero-length burst.
        applyStimulus(0, 0, 1, 0, 0, 8'd5);
        countEnables(10, highs, first, last);
        checkOutput("burst5_highs", highs, 32'd5);
        checkOutput("burst5_first", first, 32'd2);
        checkOutput("burst5_last", last, 32'd6);
        checkOutput("burst5_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);
        applyStimulus(0, 0, 1, 0, 0, 8'd0);
        countEnables(5, highs, first, last);
        checkOutput("burst0_highs", highs, 32'd0);
        checkOutput("burst0_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);

        // RUN, then cpu_halt stops it; run ignored, step still works.
        applyStimulus(0, 0, 0, 1, 0, 8'd0);
        tick(2);
        checkOutput("run_state", {29'd0, state}, {29'd0, S_RUN});
        checkOutput("run_clk_en", {31'd0, clk_en}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(1);
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        tick(1);
        checkOutput("cpuhalt_capture", {31'd0, clk_en}, 32'd1);
        tick(1);
        checkOutput("cpuhalt_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("cpuhalt_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 1, 1, 8'd0);
        countEnables(4, highs, first, last);
        checkOutput("run_blocked_highs", highs, 32'd0);
        checkOutput("run_blocked_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 1, 0, 0, 1, 8'd0);
        countEnables(5, highs, first, last);
        checkOutput("step_past_halt", highs, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);

        // Simultaneous edges follow the priority order.
        applyStimulus(1, 0, 0, 1, 0, 8'd0);
        countEnables(4, highs, first, last);
        checkOutput("halt_vs_run_highs", highs, 32'd0);
        checkOutput("halt_vs_run_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);
        applyStimulus(0, 1, 1, 0, 0, 8'd5);
        countEnables(8, highs, first, last);
        checkOutput("step_vs_burst_highs", highs, 32'd1);
        checkOutput("step_vs_burst_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);

        // Halt edge aborts a burst early.
        applyStimulus(0, 0, 1, 0, 0, 8'd8);
        tick(2);
        checkOutput("abort_burst_on", {31'd0, clk_en}, 32'd1);
        applyStimulus(1, 0, 1, 0, 0, 8'd8);
        tick(1);
        checkOutput("abort_capture", {31'd0, clk_en}, 32'd1);
        tick(1);
        checkOutput("abort_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("abort_state", {29'd0, state}, {29'd0, S_HALT});
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        tick(2);

        // Reset in the middle of a burst with the counter at 3.
        applyStimulus(0, 0, 1, 0, 0, 8'd6);
        tick(5);
        checkOutput("midburst_state", {29'd0, state}, {29'd0, S_BURST});
        checkOutput("midburst_clk_en", {31'd0, clk_en}, 32'd1);
        #2;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 8'd0);
        #1;
        checkOutput("async_mrpos", {31'd0, mr_pos}, 32'd0);
        checkOutput("async_mrneg", {31'd0, mr_neg}, 32'd0);
        checkOutput("async_clk_en", {31'd0, clk_en}, 32'd0);
        checkOutput("async_state", {29'd0, state}, {29'd0, S_RST});
`ifdef CLK_CTRL_CYCLE_COUNT_EN
        checkOutput("async_cycle_count", cycle_count, 32'd0);
`endif
        tick(2);
        reset = 1'b0;
        releaseSequence("rel2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
